data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_lane_align.sv | 64 ++++++
 rtl/data_mem_resp.sv | 168 ++++++++++++++++
 tb/tb_data_mem_resp.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and defaults for the data memory response block
//
// Purpose : Funct3 access encodings, FSM state and request-kind types, and
//           the default LATENCY/DEPTH values used by data_mem_resp.
// Ports   : none (package)
package dmem_pkg;

   localparam int DMEM_LATENCY_DEF = 2;
   localparam int DMEM_DEPTH_DEF   = 256;

   // Access size/sign; stores only use F3_B/F3_H/F3_W.
   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic {
      K_LOAD  = 1'b0,
      K_STORE = 1'b1
   } kind_e;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - combinational byte-lane steering for loads and stores
//
// Purpose : builds store byte enables and lane-replicated store data, and
//           selects/extends the addressed lane(s) of a read word for loads.
// Ports   : funct3  in  [2:0]  access size/sign
//           lane    in  [1:0]  byte offset within the word (addr[1:0])
//           wr_data in  [31:0] right-aligned store data
//           rd_word in  [31:0] word read from storage
//           be      out [3:0]  store byte enables (0 for unlisted encodings)
//           st_data out [31:0] store data replicated into every lane
//           ld_data out [31:0] extended load result (0 for unlisted encodings)
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] wr_data,
   input  logic [31:0] rd_word,
   output logic [3:0]  be,
   output logic [31:0] st_data,
   output logic [31:0] ld_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Halfwords always come from the pair {lane[1],0}; lane[0] is ignored here.
   assign byte_sel = rd_word[{lane, 3'b000} +: 8];
   assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

   // Data is replicated so the byte enables alone pick the destination lanes.
   always_comb begin
      be      = 4'b0000;
      st_data = wr_data;
      case (funct3)
         F3_B: begin
            be      = 4'b0001 << lane;
            st_data = {4{wr_data[7:0]}};
         end
         F3_H: begin
            be      = lane[1] ? 4'b1100 : 4'b0011;
            st_data = {2{wr_data[15:0]}};
         end
         F3_W: begin
            be      = 4'b1111;
            st_data = wr_data;
         end
         default: be = 4'b0000;
      endcase
   end

   always_comb begin
      ld_data = 32'h0;
      case (funct3)
         F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
         F3_W:    ld_data = rd_word;
         F3_BU:   ld_data = {24'h0, byte_sel};
         F3_HU:   ld_data = {16'h0, half_sel};
         default: ld_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - multi-cycle data memory with load/store response FSM
//
// Purpose : accepts one load or store at a time, completes it LATENCY cycles
//           after acceptance, stalls the pipeline meanwhile, and presents the
//           extended load result in the DONE cycle.
// Ports   : clk       in        clock, all state on rising edge
//           reset     in        synchronous active-high reset
//           MemRead   in        load request
//           MemWrite  in        store request (wins when both are set)
//           Funct3    in  [2:0] access size/sign
//           addr      in  [31:0] byte address
//           wr_data   in  [31:0] right-aligned store data
//           rd_data   out [31:0] load result, 0 unless rd_valid
//           rd_valid  out       load result valid (DONE of a load)
//           stall     out       hold upstream while an access is pending
//           misalign  out       misaligned access flag in DONE
// Config  : DMEM_MISALIGN_CHECK_EN enables misaligned-access detection;
//           without it misalign is tied 0 and low address bits are ignored
//           beyond lane selection.
module data_mem_resp
   import dmem_pkg::*;
#(
   parameter int LATENCY = DMEM_LATENCY_DEF,
   parameter int DEPTH   = DMEM_DEPTH_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        stall,
   output logic        misalign
);

   localparam int         IDX_W    = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_e            state, state_d;
   logic [3:0]        cnt, cnt_d;
   logic              req;

   logic [2:0]        f3_q;
   logic [IDX_W+1:0]  addr_q;
   logic [31:0]       wdata_q;
   kind_e             kind_q;

   logic [IDX_W-1:0]  word_idx;
   logic [31:0]       rd_word;
   logic [3:0]        be;
   logic [31:0]       st_data;
   logic [31:0]       ld_data;
   logic              mis_acc;
   logic              done;
   logic              mem_we;
   logic              unused_addr;

   logic [31:0]       mem [DEPTH];

   assign req         = MemRead | MemWrite;
   assign unused_addr = ^addr[31:IDX_W+2];

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // Request operands are only captured on acceptance; later request-line
   // activity during BUSY/DONE cannot disturb the access in flight.
   always_ff @(posedge clk) begin
      if (state == IDLE && req) begin
         f3_q    <= Funct3;
         addr_q  <= addr[IDX_W+1:0];
         wdata_q <= wr_data;
         kind_q  <= MemWrite ? K_STORE : K_LOAD;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      stall   = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               stall = 1'b1;
               if (LATENCY == 1) begin
                  state_d = DONE;
                  cnt_d   = 4'd0;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (cnt <= 4'd1) begin
               state_d = DONE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (reset) begin
         stall = 1'b0;
      end
   end

   // Word index wraps modulo DEPTH; for power-of-two depths this is a slice.
   assign word_idx = IDX_W'(32'(addr_q[IDX_W+1:2]) % DEPTH);
   assign rd_word  = mem[word_idx];

   dmem_lane_align u_align (
      .funct3  (f3_q),
      .lane    (addr_q[1:0]),
      .wr_data (wdata_q),
      .rd_word (rd_word),
      .be      (be),
      .st_data (st_data),
      .ld_data (ld_data)
   );

`ifdef DMEM_MISALIGN_CHECK_EN
   // 101 is not a store encoding, so it only counts as misaligned for loads.
   always_comb begin
      mis_acc = 1'b0;
      case (f3_q)
         F3_H:    mis_acc = addr_q[0];
         F3_HU:   mis_acc = (kind_q == K_LOAD) && addr_q[0];
         F3_W:    mis_acc = (addr_q[1:0] != 2'b00);
         default: mis_acc = 1'b0;
      endcase
   end
`else
   assign mis_acc = 1'b0;
`endif

   assign done     = (state == DONE);
   assign misalign = done && mis_acc;
   assign rd_valid = done && (kind_q == K_LOAD);
   assign rd_data  = (rd_valid && !mis_acc) ? ld_data : 32'h0;

   // Commit happens at the edge closing DONE, so a reset in DONE also aborts.
   assign mem_we = done && (kind_q == K_STORE) && !mis_acc && !reset;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_resp.sv
// tb/tb_data_mem_resp.sv - randomized self-checking bench for data_mem_resp
//
// Purpose : two instances (LATENCY 2/DEPTH 256 and LATENCY 1/DEPTH 16) are
//           driven with directed and random accesses and compared against a
//           word-array reference model.
// Ports   : none
module tb_data_mem_resp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset0, rd0, wr0, reset1, rd1, wr1;
   logic [2:0]  f30, f31;
   logic [31:0] a0, wd0, a1, wd1;
   logic [31:0] rdata0, rdata1;
   logic        val0, val1, stall0, stall1, mis0, mis1;

   data_mem_resp #(.LATENCY(2), .DEPTH(256)) u_dut0 (
      .clk(clk), .reset(reset0), .MemRead(rd0), .MemWrite(wr0), .Funct3(f30),
      .addr(a0), .wr_data(wd0), .rd_data(rdata0), .rd_valid(val0),
      .stall(stall0), .misalign(mis0)
   );

   data_mem_resp #(.LATENCY(1), .DEPTH(16)) u_dut1 (
      .clk(clk), .reset(reset1), .MemRead(rd1), .MemWrite(wr1), .Funct3(f31),
      .addr(a1), .wr_data(wd1), .rd_data(rdata1), .rd_valid(val1),
      .stall(stall1), .misalign(mis1)
   );

   int          lat [2] = '{2, 1};
   int          dep [2] = '{256, 16};
   logic [31:0] ref_mem [2][256];
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic drive(int d, logic r, logic w, logic [2:0] f, logic [31:0] a, logic [31:0] wd);
      if (d == 0) begin
         rd0 = r; wr0 = w; f30 = f; a0 = a; wd0 = wd;
      end else begin
         rd1 = r; wr1 = w; f31 = f; a1 = a; wd1 = wd;
      end
   endtask

   function automatic logic [31:0] o_rd(int d);
      return (d == 0) ? rdata0 : rdata1;
   endfunction
   function automatic logic [31:0] o_val(int d);
      return {31'b0, (d == 0) ? val0 : val1};
   endfunction
   function automatic logic [31:0] o_stall(int d);
      return {31'b0, (d == 0) ? stall0 : stall1};
   endfunction
   function automatic logic [31:0] o_mis(int d);
      return {31'b0, (d == 0) ? mis0 : mis1};
   endfunction

   // Reference: applies the access to ref_mem and returns the expected result.
   task automatic model_access(int d, logic store, logic [2:0] f, logic [31:0] a,
                               logic [31:0] wd, output logic [31:0] exp_rd,
                               output logic exp_mis);
      int          idx;
      int          off;
      int          sh;
      logic [31:0] word, bytev, halfv;
      idx     = int'((a >> 2) % dep[d]);
      off     = int'(a % 4);
      word    = ref_mem[d][idx];
      exp_mis = 1'b0;
      exp_rd  = 32'h0;
`ifdef DMEM_MISALIGN_CHECK_EN
      if ((f == 3'd1 || (!store && f == 3'd5)) && (off % 2 == 1)) exp_mis = 1'b1;
      if (f == 3'd2 && off != 0) exp_mis = 1'b1;
`endif
      if (!exp_mis) begin
         if (store) begin
            case (f)
               3'd0: begin
                  sh   = 8 * off;
                  word = (word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
               end
               3'd1: begin
                  sh   = (off >= 2) ? 16 : 0;
                  word = (word & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
               end
               3'd2: word = wd;
               default: ;
            endcase
            ref_mem[d][idx] = word;
         end else begin
            bytev = (word >> (8 * off)) & 32'hFF;
            halfv = (word >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
            case (f)
               3'd0: exp_rd = (bytev >= 128) ? bytev + 32'hFFFFFF00 : bytev;
               3'd1: exp_rd = (halfv >= 32768) ? halfv + 32'hFFFF0000 : halfv;
               3'd2: exp_rd = word;
               3'd4: exp_rd = bytev;
               3'd5: exp_rd = halfv;
               default: exp_rd = 32'h0;
            endcase
         end
      end
   endtask

   task automatic access(int d, logic r, logic w, logic [2:0] f, logic [31:0] a,
                         logic [31:0] wd, output logic [31:0] got_rd);
      logic [31:0] exp_rd;
      logic        exp_mis;
      model_access(d, w, f, a, wd, exp_rd, exp_mis);
      got_rd = 32'h0;
      @(negedge clk);
      drive(d, r, w, f, a, wd);
      #1;
      check("req_stall", o_stall(d), 32'd1);
      check("req_valid", o_val(d), 32'd0);
      for (int k = 1; k <= lat[d]; k++) begin
         @(negedge clk);
         // Request lines are ignored after acceptance; scramble them.
         drive(d, 1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom);
         #1;
         if (k < lat[d]) begin
            check("busy_stall", o_stall(d), 32'd1);
            check("busy_valid", o_val(d), 32'd0);
            check("busy_data", o_rd(d), 32'h0);
            check("busy_mis", o_mis(d), 32'd0);
         end else begin
            check("done_stall", o_stall(d), 32'd0);
            check("done_valid", o_val(d), {31'b0, !w});
            check("done_data", o_rd(d), exp_rd);
            check("done_mis", o_mis(d), {31'b0, exp_mis});
            got_rd = o_rd(d);
         end
      end
      drive(d, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
   endtask

   initial begin
      logic [31:0] got;
      int          op;
      reset0 = 1'b1;
      reset1 = 1'b1;
      drive(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("rst_data", o_rd(d), 32'h0);
         check("rst_valid", o_val(d), 32'd0);
         check("rst_stall", o_stall(d), 32'd0);
         check("rst_mis", o_mis(d), 32'd0);
      end
      reset0 = 1'b0;
      reset1 = 1'b0;

      // Give every word a known value.
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < dep[d]; i++)
            access(d, 1'b0, 1'b1, 3'd2, 32'(i * 4), $urandom, got);

      // Store/load round trip and byte merging.
      access(0, 1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, got);
      access(0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, got);
      check("lw_10", got, 32'hDEADBEEF);
      access(0, 1'b0, 1'b1, 3'd0, 32'h13, 32'h80, got);
      access(0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, got);
      check("lw_after_sb", got, 32'h80ADBEEF);
      access(0, 1'b1, 1'b0, 3'd0, 32'h13, 32'h0, got);
      check("lb_13", got, 32'hFFFFFF80);
      access(0, 1'b1, 1'b0, 3'd4, 32'h13, 32'h0, got);
      check("lbu_13", got, 32'h00000080);

      // Single-cycle latency instance.
      access(1, 1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, got);
      access(1, 1'b0, 1'b1, 3'd0, 32'h13, 32'h80, got);
      access(1, 1'b1, 1'b0, 3'd1, 32'h12, 32'h0, got);
      check("lh_12_lat1", got, 32'hFFFF80AD);

      // Both request lines: treated as a store.
      access(0, 1'b1, 1'b1, 3'd2, 32'h30, 32'hA5A5A5A5, got);
      access(0, 1'b1, 1'b0, 3'd2, 32'h30, 32'h0, got);
      check("lw_30_both", got, 32'hA5A5A5A5);

`ifdef DMEM_MISALIGN_CHECK_EN
      access(0, 1'b1, 1'b0, 3'd2, 32'h11, 32'h0, got);
      check("lw_11_mis", got, 32'h0);
      access(0, 1'b0, 1'b1, 3'd2, 32'h11, 32'hFFFFFFFF, got);
      access(0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, got);
      check("sw_11_suppressed", got, 32'h80ADBEEF);
`endif

      // Reset during BUSY aborts the store.
      @(negedge clk);
      drive(0, 1'b0, 1'b1, 3'd2, 32'h20, 32'h12345678);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      reset0 = 1'b1;
      @(negedge clk);
      reset0 = 1'b0;
      #1;
      check("abort_stall", o_stall(0), 32'd0);
      check("abort_valid", o_val(0), 32'd0);
      repeat (3) begin
         @(negedge clk);
         #1;
         check("abort_idle_stall", o_stall(0), 32'd0);
         check("abort_idle_valid", o_val(0), 32'd0);
      end
      access(0, 1'b1, 1'b0, 3'd2, 32'h20, 32'h0, got);
      check("lw_20_prior", got, ref_mem[0][8]);

      // Random traffic, including unlisted encodings and wrapping addresses.
      for (int n = 0; n < 500; n++) begin
         int d;
         d  = (n % 5 < 3) ? 0 : 1;
         op = int'($urandom_range(0, 2));
         access(d, op != 1, op != 0, 3'($urandom), $urandom, $urandom, got);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
